// File: rtl/modbus_pkg.sv
// Shared Modbus definitions for the holding-register bank.
//   MB_DW / MB_AW      : Modbus data and address widths.
//   OFS_*              : housekeeping register offsets, relative to BASE_ADDR+N_REGS.
//   mb_sel_e/mb_decode : classify an address offset (already relative to BASE_ADDR).
package modbus_pkg;

  localparam int unsigned MB_DW = 16;
  localparam int unsigned MB_AW = 16;

  localparam int unsigned OFS_STATUS = 0;
  localparam int unsigned OFS_SEC_LO = 1;
  localparam int unsigned OFS_SEC_HI = 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_STATUS,
    SEL_SEC_LO,
    SEL_SEC_HI
  } mb_sel_e;

  function automatic mb_sel_e mb_decode(input logic [MB_AW-1:0] ofs,
                                        input int unsigned      n_regs);
    logic [MB_AW-1:0] n;
    n = MB_AW'(n_regs);
    if (ofs < n)                             return SEL_DATA;
    else if (ofs == n + MB_AW'(OFS_STATUS))  return SEL_STATUS;
    else if (ofs == n + MB_AW'(OFS_SEC_LO))  return SEL_SEC_LO;
    else if (ofs == n + MB_AW'(OFS_SEC_HI))  return SEL_SEC_HI;
    else                                     return SEL_NONE;
  endfunction

endpackage

// File: rtl/modbus_holding_bank_if.sv
// Read/write register port between modbus_slave and a holding-register bank.
//   iAddrRd : read address           oDataRd : read data (combinational)
//   oHit    : read address in map    iAddrWr / iDataWr / iWrEn : write port
// master = slave-protocol engine side, slave = register bank side.
interface modbus_holding_bank_if;
  import modbus_pkg::*;

  logic [MB_AW-1:0] iAddrRd;
  logic [MB_DW-1:0] oDataRd;
  logic             oHit;
  logic [MB_AW-1:0] iAddrWr;
  logic [MB_DW-1:0] iDataWr;
  logic             iWrEn;

  modport master (
    output iAddrRd, iAddrWr, iDataWr, iWrEn,
    input  oDataRd, oHit
  );

  modport slave (
    input  iAddrRd, iAddrWr, iDataWr, iWrEn,
    output oDataRd, oHit
  );
endinterface

// File: rtl/mb_sec_counter.sv
// Uptime seconds counter with prescaler and half-word load.
//   clk, rst          : clock, asynchronous active-high reset
//   iLdLo / iLdHi     : load iLdData into oSeconds[15:0] / [31:16]; restarts the prescaler
//   iLdData           : load value
//   oSeconds          : 32-bit seconds count (wraps)
//   oSecPulse         : one-cycle pulse on each increment
//   oBlink            : toggles on each increment
module mb_sec_counter
  import modbus_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iLdLo,
  input  logic             iLdHi,
  input  logic [MB_DW-1:0] iLdData,
  output logic [31:0]      oSeconds,
  output logic             oSecPulse,
  output logic             oBlink
);

  if (TICKS_PER_SEC < 2) begin : g_bad_tps
    $error("mb_sec_counter: TICKS_PER_SEC must be >= 2");
  end

  localparam logic [31:0] TICK_TERM = 32'(TICKS_PER_SEC - 1);

  logic [31:0] tick_q, tick_d;
  logic [31:0] sec_q, sec_d;
  logic        pulse_q, pulse_d;
  logic        blink_q, blink_d;

  // A load owns the cycle: the prescaler restarts and no increment occurs.
  always_comb begin : p_next
    tick_d  = tick_q + 32'd1;
    sec_d   = sec_q;
    pulse_d = 1'b0;
    blink_d = blink_q;
    if (iLdLo || iLdHi) begin
      tick_d = '0;
      if (iLdLo) sec_d[15:0]  = iLdData;
      if (iLdHi) sec_d[31:16] = iLdData;
    end else if (tick_q == TICK_TERM) begin
      tick_d  = '0;
      sec_d   = sec_q + 32'd1;
      pulse_d = 1'b1;
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      tick_q  <= '0;
      sec_q   <= '0;
      pulse_q <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      sec_q   <= sec_d;
      pulse_q <= pulse_d;
      blink_q <= blink_d;
    end
  end

  assign oSeconds  = sec_q;
  assign oSecPulse = pulse_q;
  assign oBlink    = blink_q;

endmodule

// File: rtl/modbus_holding_bank.sv
// Parametrised bank of Modbus holding registers plus housekeeping registers.
// Map relative to BASE_ADDR: +i data register i, +N_REGS STATUS (sticky
// written-since-clear flags, write-1-to-clear), +N_REGS+1 SEC_LO, +N_REGS+2 SEC_HI.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : read/write port (slave modport); oDataRd/oHit are combinational
//   iRoData   : live values for read-only registers (RO_MASK bits set)
//   oRegs     : register contents (RO slices mirror iRoData)
//   oWrStb    : per-register one-cycle write pulse
//   oSeconds, oSecPulse, oBlink : uptime counter outputs
module modbus_holding_bank
  import modbus_pkg::*;
#(
  parameter int unsigned              N_REGS        = 4,
  parameter logic [MB_AW-1:0]         BASE_ADDR     = 16'h0002,
  parameter logic [N_REGS*MB_DW-1:0]  RESET_VALS    = '0,
  parameter logic [N_REGS-1:0]        RO_MASK       = '0,
  parameter int unsigned              TICKS_PER_SEC = 10_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  modbus_holding_bank_if.slave      bus,
  input  logic [N_REGS*MB_DW-1:0]   iRoData,
  output logic [N_REGS*MB_DW-1:0]   oRegs,
  output logic [N_REGS-1:0]         oWrStb,
  output logic [31:0]               oSeconds,
  output logic                      oSecPulse,
  output logic                      oBlink
);

  if (N_REGS < 1 || N_REGS > 16) begin : g_bad_n
    $error("modbus_holding_bank: N_REGS must be 1..16");
  end
  if (32'(BASE_ADDR) + 32'(N_REGS) + 32'(OFS_SEC_HI) > 32'hFFFF) begin : g_bad_map
    $error("modbus_holding_bank: address map crosses 16'hFFFF");
  end

  logic [N_REGS-1:0][MB_DW-1:0] regs_q, regs_d;
  logic [N_REGS-1:0][MB_DW-1:0] reg_view;
  logic [N_REGS-1:0]            status_q, status_d;
  logic [N_REGS-1:0]            wr_stb_q, wr_stb_d;
  logic [15:0]                  shadow_hi_q, shadow_hi_d;

  logic [MB_AW-1:0] rd_ofs, wr_ofs;
  mb_sel_e          rd_sel, wr_sel;
  logic [MB_DW-1:0] data_rd;
  logic             ld_lo, ld_hi;
  logic [31:0]      seconds;

  always_comb begin : p_decode
    rd_ofs = bus.iAddrRd - BASE_ADDR;
    wr_ofs = bus.iAddrWr - BASE_ADDR;
    rd_sel = mb_decode(rd_ofs, N_REGS);
    wr_sel = mb_decode(wr_ofs, N_REGS);
  end

  always_comb begin : p_view
    for (int unsigned i = 0; i < N_REGS; i++) begin
      reg_view[i] = RO_MASK[i] ? iRoData[i*MB_DW +: MB_DW] : regs_q[i];
    end
  end

  always_comb begin : p_write
    regs_d   = regs_q;
    status_d = status_q;
    wr_stb_d = '0;
    ld_lo    = 1'b0;
    ld_hi    = 1'b0;
    if (bus.iWrEn) begin
      case (wr_sel)
        SEL_STATUS: status_d = status_q & ~bus.iDataWr[N_REGS-1:0];
        SEL_SEC_LO: ld_lo = 1'b1;
        SEL_SEC_HI: ld_hi = 1'b1;
        SEL_DATA: begin
          for (int unsigned i = 0; i < N_REGS; i++) begin
            if (wr_ofs == MB_AW'(i) && !RO_MASK[i]) begin
              regs_d[i]   = bus.iDataWr;
              wr_stb_d[i] = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    // Set is applied after clear so a coincident set wins.
    status_d = status_d | wr_stb_d;
  end

  // Capturing the high half while SEC_LO is addressed makes an ascending
  // LO-then-HI read coherent even if the counter carries in between.
  always_comb begin : p_shadow
    shadow_hi_d = shadow_hi_q;
    if (rd_sel == SEL_SEC_LO) shadow_hi_d = seconds[31:16];
  end

  always_comb begin : p_read
    data_rd = '0;
    case (rd_sel)
      SEL_DATA: begin
        for (int unsigned i = 0; i < N_REGS; i++) begin
          if (rd_ofs == MB_AW'(i)) data_rd = reg_view[i];
        end
      end
      SEL_STATUS: data_rd[N_REGS-1:0] = status_q;
      SEL_SEC_LO: data_rd = seconds[15:0];
      SEL_SEC_HI: data_rd = shadow_hi_q;
      default:    data_rd = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      regs_q      <= RESET_VALS;
      status_q    <= '0;
      wr_stb_q    <= '0;
      shadow_hi_q <= '0;
    end else begin
      regs_q      <= regs_d;
      status_q    <= status_d;
      wr_stb_q    <= wr_stb_d;
      shadow_hi_q <= shadow_hi_d;
    end
  end

  mb_sec_counter #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec (
    .clk       (clk),
    .rst       (rst),
    .iLdLo     (ld_lo),
    .iLdHi     (ld_hi),
    .iLdData   (bus.iDataWr),
    .oSeconds  (seconds),
    .oSecPulse (oSecPulse),
    .oBlink    (oBlink)
  );

  assign bus.oDataRd = data_rd;
  assign bus.oHit    = (rd_sel != SEL_NONE);
  assign oRegs       = reg_view;
  assign oWrStb      = wr_stb_q;
  assign oSeconds    = seconds;

endmodule

// File: tb/tb_modbus_holding_bank.sv
module tb_modbus_holding_bank;

  localparam logic [63:0] RV = {16'h0000, 16'h920E, 16'h0000, 16'h1234};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] ro_a = '0;
  logic [63:0] ro_b = 64'h0000_0000_0000_5555;
  logic [63:0] regs_a, regs_b;
  logic [3:0]  stb_a, stb_b;
  logic [31:0] sec_a, sec_b;
  logic        pulse_a, pulse_b, blink_a, blink_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modbus_holding_bank_if bus_a ();
  modbus_holding_bank_if bus_b ();

  modbus_holding_bank #(
    .N_REGS(4), .BASE_ADDR(16'h0002), .RESET_VALS(RV),
    .RO_MASK(4'b0000), .TICKS_PER_SEC(4)
  ) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .iRoData(ro_a), .oRegs(regs_a),
    .oWrStb(stb_a), .oSeconds(sec_a), .oSecPulse(pulse_a), .oBlink(blink_a)
  );

  modbus_holding_bank #(
    .N_REGS(4), .BASE_ADDR(16'h0002), .RESET_VALS(RV),
    .RO_MASK(4'b0001), .TICKS_PER_SEC(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .iRoData(ro_b), .oRegs(regs_b),
    .oWrStb(stb_b), .oSeconds(sec_b), .oSecPulse(pulse_b), .oBlink(blink_b)
  );

  typedef struct {
    logic        we;
    logic [15:0] wa;
    logic [15:0] wd;
    logic [15:0] ra;
    logic [15:0] exp_rd;
    logic        exp_hit;
    logic [3:0]  exp_stb;
    logic [63:0] exp_regs;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wr_a(input logic [15:0] a, input logic [15:0] d);
    bus_a.iWrEn   = 1'b1;
    bus_a.iAddrWr = a;
    bus_a.iDataWr = d;
    step();
    bus_a.iWrEn   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r0, r1, r2, r3;
    r0 = RV;
    r1 = {16'h0000, 16'h920E, 16'hABCD, 16'h1234};
    r2 = {16'hBEEF, 16'h920E, 16'hABCD, 16'h1234};
    r3 = {16'hBEEF, 16'h920E, 16'hABCD, 16'h0042};
    //           we    wa      wd       ra      exp_rd  hit   stb      regs
    vecs[0]  = '{1'b0, 16'h0, 16'h0000, 16'd2,  16'h1234, 1'b1, 4'b0000, r0};
    vecs[1]  = '{1'b0, 16'h0, 16'h0000, 16'd3,  16'h0000, 1'b1, 4'b0000, r0};
    vecs[2]  = '{1'b0, 16'h0, 16'h0000, 16'd4,  16'h920E, 1'b1, 4'b0000, r0};
    vecs[3]  = '{1'b0, 16'h0, 16'h0000, 16'd5,  16'h0000, 1'b1, 4'b0000, r0};
    vecs[4]  = '{1'b0, 16'h0, 16'h0000, 16'd6,  16'h0000, 1'b1, 4'b0000, r0};
    vecs[5]  = '{1'b0, 16'h0, 16'h0000, 16'd1,  16'h0000, 1'b0, 4'b0000, r0};
    vecs[6]  = '{1'b0, 16'h0, 16'h0000, 16'd9,  16'h0000, 1'b0, 4'b0000, r0};
    vecs[7]  = '{1'b1, 16'd3, 16'hABCD, 16'd3,  16'hABCD, 1'b1, 4'b0010, r1};
    vecs[8]  = '{1'b0, 16'h0, 16'h0000, 16'd6,  16'h0002, 1'b1, 4'b0000, r1};
    vecs[9]  = '{1'b1, 16'd6, 16'h0002, 16'd6,  16'h0000, 1'b1, 4'b0000, r1};
    vecs[10] = '{1'b1, 16'd5, 16'hBEEF, 16'd5,  16'hBEEF, 1'b1, 4'b1000, r2};
    vecs[11] = '{1'b1, 16'd2, 16'h0042, 16'd6,  16'h0009, 1'b1, 4'b0001, r3};
    vecs[12] = '{1'b1, 16'd6, 16'h0001, 16'd6,  16'h0008, 1'b1, 4'b0000, r3};
    vecs[13] = '{1'b1, 16'd6, 16'hFFFF, 16'd6,  16'h0000, 1'b1, 4'b0000, r3};
    vecs[14] = '{1'b1, 16'd10, 16'h0001, 16'd2, 16'h0042, 1'b1, 4'b0000, r3};
    vecs[15] = '{1'b0, 16'h0, 16'h0000, 16'd6,  16'h0000, 1'b1, 4'b0000, r3};

    bus_a.iAddrRd = '0; bus_a.iAddrWr = '0; bus_a.iDataWr = '0; bus_a.iWrEn = 1'b0;
    bus_b.iAddrRd = '0; bus_b.iAddrWr = '0; bus_b.iDataWr = '0; bus_b.iWrEn = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Table: each vector spans one edge; checks see the post-edge state.
    for (int i = 0; i < 16; i++) begin
      bus_a.iWrEn   = vecs[i].we;
      bus_a.iAddrWr = vecs[i].wa;
      bus_a.iDataWr = vecs[i].wd;
      bus_a.iAddrRd = vecs[i].ra;
      step();
      bus_a.iWrEn   = 1'b0;
      chk($sformatf("vec%0d_rd", i),   64'(bus_a.oDataRd), 64'(vecs[i].exp_rd));
      chk($sformatf("vec%0d_hit", i),  64'(bus_a.oHit),    64'(vecs[i].exp_hit));
      chk($sformatf("vec%0d_stb", i),  64'(stb_a),         64'(vecs[i].exp_stb));
      chk($sformatf("vec%0d_regs", i), regs_a,             vecs[i].exp_regs);
    end

    // Read-only register on the second bank.
    bus_b.iWrEn = 1'b1; bus_b.iAddrWr = 16'd2; bus_b.iDataWr = 16'h1111; bus_b.iAddrRd = 16'd2;
    step();
    bus_b.iWrEn = 1'b0;
    chk("ro_stb",  64'(stb_b),         64'h0);
    chk("ro_rd",   64'(bus_b.oDataRd), 64'h5555);
    chk("ro_regs", 64'(regs_b[15:0]),  64'h5555);
    bus_b.iAddrRd = 16'd6;
    #1;
    chk("ro_status", 64'(bus_b.oDataRd), 64'h0);
    bus_b.iWrEn = 1'b1; bus_b.iAddrWr = 16'd3; bus_b.iDataWr = 16'h2222;
    step();
    bus_b.iWrEn = 1'b0;
    chk("ro_bank_rw_stb", 64'(stb_b), 64'h2);

    // Asynchronous reset with a strobe pending and a status bit set.
    bus_a.iAddrRd = 16'd6;
    wr_a(16'd2, 16'h7777);
    chk("pre_rst_stb", 64'(stb_a), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_regs",   regs_a,               RV);
    chk("rst_stb",    64'(stb_a),           64'h0);
    chk("rst_sec",    64'(sec_a),           64'h0);
    chk("rst_pulse",  64'(pulse_a),         64'h0);
    chk("rst_blink",  64'(blink_a),         64'h0);
    chk("rst_status", 64'(bus_a.oDataRd),   64'h0);
    step();
    rst = 1'b0;

    // Counter restarts from 0: pulse on every 4th edge after release.
    for (int n = 1; n <= 12; n++) begin
      step();
      chk($sformatf("cnt%0d_pulse", n), 64'(pulse_a), 64'((n % 4) == 0));
      chk($sformatf("cnt%0d_sec", n),   64'(sec_a),   64'(n / 4));
      chk($sformatf("cnt%0d_blink", n), 64'(blink_a), 64'((n / 4) % 2));
    end

    // Half-word load then carry from the low half.
    wr_a(16'd7, 16'hFFFF);
    wr_a(16'd8, 16'h0000);
    chk("ld_sec",   64'(sec_a),   64'h0000_FFFF);
    chk("ld_pulse", 64'(pulse_a), 64'h0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("carry%0d_sec", k),   64'(sec_a),   (k < 4) ? 64'h0000_FFFF : 64'h0001_0000);
      chk($sformatf("carry%0d_pulse", k), 64'(pulse_a), 64'(k == 4));
    end

    // Tear-free read across the carry.
    wr_a(16'd7, 16'hFFFF);
    wr_a(16'd8, 16'h0000);
    step();
    step();
    step();
    bus_a.iAddrRd = 16'd7;
    #1;
    chk("tear_lo", 64'(bus_a.oDataRd), 64'hFFFF);
    step();
    bus_a.iAddrRd = 16'd8;
    #1;
    chk("tear_hi",  64'(bus_a.oDataRd), 64'h0000);
    chk("tear_sec", 64'(sec_a),         64'h0001_0000);
    bus_a.iAddrRd = 16'd7;
    step();
    bus_a.iAddrRd = 16'd8;
    #1;
    chk("shadow_refresh", 64'(bus_a.oDataRd), 64'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
